// File: rtl/max_pool_grid.sv
// Grid max-pooling over event features: each event updates one cell's running
// channel-wise maximum, LANES channels per cycle. Define MAX_POOL_DX_EN to also output new-max minus old-max.
package aegnn;
  localparam int F_WIDTH = 8;
  typedef logic [7:0] x_idx_t;
  typedef logic [7:0] y_idx_t;
  typedef logic [5:0] grid_idx_t;
endpackage

module max_pool_grid
  import aegnn::*;
#(
  parameter int L_OUT_C    = 32,
  parameter int LANES      = 8,
  parameter int GRID_W     = 8,
  parameter int GRID_H     = 8,
  parameter int CELL_SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       module_start,
  input  logic                       event_stream_clean,
  input  x_idx_t                     new_event_x,
  input  y_idx_t                     new_event_y,
  input  logic [L_OUT_C*F_WIDTH-1:0] last_layer_out_pack,
  output logic                       module_busy,
  output logic                       module_done,
  output grid_idx_t                  grid_idx,
  output logic                       cell_first,
  output logic [L_OUT_C*F_WIDTH-1:0] max_pool_x_out_pack,
  output logic [L_OUT_C*F_WIDTH-1:0] max_pool_dx_out_pack
);
  localparam int NCELLS = GRID_W * GRID_H;
  localparam int NBEATS = L_OUT_C / LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PW     = L_OUT_C * F_WIDTH;
  localparam int LW     = LANES * F_WIDTH;
  localparam int PIW    = $clog2(PW);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_PROC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [NCELLS-1:0] valid_q, valid_d;
  logic [PW-1:0]     feat_q, feat_d;
  logic [PW-1:0]     out_q, out_d;
  grid_idx_t         idx_q, idx_d, idx_new;
  logic              first_q, first_d;
  logic [PW-1:0]     mem_q [NCELLS];

  logic [LW-1:0]      new_lanes, old_lanes, max_lanes;
  logic [F_WIDTH-1:0] n_v, o_v;
  logic [PIW-1:0]     base;
  int unsigned        cx, cy;
  logic               accept;

  always_comb begin
    cx = 32'(new_event_x) >> CELL_SHIFT;
    cy = 32'(new_event_y) >> CELL_SHIFT;
    if (cx > GRID_W - 1) cx = GRID_W - 1;
    if (cy > GRID_H - 1) cy = GRID_H - 1;
    idx_new = grid_idx_t'(cy * GRID_W + cx);
  end

  // The latched cell_first gates the old value, so an invalid cell reads as zero
  // regardless of what stale data its storage holds.
  always_comb begin
    base      = PIW'(32'(beat_q) * LW);
    new_lanes = feat_q[base +: LW];
    old_lanes = first_q ? '0 : mem_q[idx_q][base +: LW];
    max_lanes = '0;
    n_v       = '0;
    o_v       = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      n_v = new_lanes[l*F_WIDTH +: F_WIDTH];
      o_v = old_lanes[l*F_WIDTH +: F_WIDTH];
      max_lanes[l*F_WIDTH +: F_WIDTH] = (n_v > o_v) ? n_v : o_v;
    end
  end

  assign accept = (state_q == S_IDLE) && module_start && !event_stream_clean;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    feat_d  = feat_q;
    out_d   = out_q;
    idx_d   = idx_q;
    first_d = first_q;
    if (event_stream_clean) begin
      state_d = S_IDLE;
      valid_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          state_d = S_CAPT;
          feat_d  = last_layer_out_pack;
          idx_d   = idx_new;
          first_d = !valid_q[idx_new];
        end
        S_CAPT: begin
          state_d = S_PROC;
          beat_d  = '0;
        end
        S_PROC: begin
          out_d[base +: LW] = max_lanes;
          if (beat_q == LAST_BEAT) begin
            state_d        = S_DONE;
            valid_d[idx_q] = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      valid_q <= '0;
      feat_q  <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      feat_q  <= feat_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      first_q <= first_d;
    end
  end

  // Feature storage has no reset; validity lives solely in valid_q.
  always_ff @(posedge clk) begin
    if (state_q == S_PROC) mem_q[idx_q][base +: LW] <= max_lanes;
  end

`ifdef MAX_POOL_DX_EN
  logic [PW-1:0] dx_q, dx_d;
  logic [LW-1:0] dx_lanes;

  always_comb begin
    dx_lanes = '0;
    for (int unsigned l = 0; l < LANES; l++)
      dx_lanes[l*F_WIDTH +: F_WIDTH] = max_lanes[l*F_WIDTH +: F_WIDTH] - old_lanes[l*F_WIDTH +: F_WIDTH];
    dx_d = dx_q;
    if (state_q == S_PROC && !event_stream_clean) dx_d[base +: LW] = dx_lanes;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dx_q <= '0;
    else       dx_q <= dx_d;
  end

  assign max_pool_dx_out_pack = dx_q;
`else
  assign max_pool_dx_out_pack = '0;
`endif

  assign module_busy         = (state_q != S_IDLE);
  assign module_done         = (state_q == S_DONE);
  assign grid_idx            = idx_q;
  assign cell_first          = first_q;
  assign max_pool_x_out_pack = out_q;
endmodule

// File: tb/tb_max_pool_grid.sv
// Self-checking bench for max_pool_grid: directed vector table, abort/reset
// sequences and randomized events against a per-cell array reference model.
module tb_max_pool_grid;
  import aegnn::*;

  localparam int LC = 32;
  localparam int GW = 8;
  localparam int GH = 8;
  localparam int CS = 4;
  localparam int F  = F_WIDTH;
  localparam int PW = LC * F;
  localparam int NC = GW * GH;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          module_start = 1'b0;
  logic          event_stream_clean = 1'b0;
  x_idx_t        new_event_x = '0;
  y_idx_t        new_event_y = '0;
  logic [PW-1:0] last_layer_out_pack = '0;
  logic          module_busy, module_done, cell_first;
  grid_idx_t     grid_idx;
  logic [PW-1:0] max_pool_x_out_pack, max_pool_dx_out_pack;

  max_pool_grid #(.L_OUT_C(LC), .LANES(8), .GRID_W(GW), .GRID_H(GH), .CELL_SHIFT(CS)) dut (
    .clk(clk), .rstn(rstn), .module_start(module_start), .event_stream_clean(event_stream_clean),
    .new_event_x(new_event_x), .new_event_y(new_event_y), .last_layer_out_pack(last_layer_out_pack),
    .module_busy(module_busy), .module_done(module_done), .grid_idx(grid_idx), .cell_first(cell_first),
    .max_pool_x_out_pack(max_pool_x_out_pack), .max_pool_dx_out_pack(max_pool_dx_out_pack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  always @(negedge clk) if (module_done === 1'b1) done_cnt++;

  int mfeat [NC][LC];
  bit mvalid [NC];
  int fv [LC];
  logic [PW-1:0] exp_out, exp_dx;
  int exp_idx;
  bit exp_first;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack_fv();
    logic [PW-1:0] p = '0;
    for (int i = 0; i < LC; i++) p[i*F +: F] = F'(fv[i]);
    return p;
  endfunction

  task automatic set_fv(input int mode);
    for (int i = 0; i < LC; i++)
      case (mode)
        0: fv[i] = i + 1;
        1: fv[i] = (i < 31) ? i + 2 : 1;
        2: fv[i] = i;
        default: fv[i] = int'($urandom_range(0, 255));
      endcase
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) mvalid[c] = 1'b0;
  endtask

  task automatic model_event(input int x, input int y);
    int cx, cy, c, old, o;
    cx = x / (1 << CS); if (cx > GW - 1) cx = GW - 1;
    cy = y / (1 << CS); if (cy > GH - 1) cy = GH - 1;
    c = cy * GW + cx;
    exp_idx = c;
    exp_first = !mvalid[c];
    for (int i = 0; i < LC; i++) begin
      old = mvalid[c] ? mfeat[c][i] : 0;
      o = (fv[i] > old) ? fv[i] : old;
      exp_out[i*F +: F] = F'(o);
`ifdef MAX_POOL_DX_EN
      exp_dx[i*F +: F] = F'(o - old);
`else
      exp_dx[i*F +: F] = '0;
`endif
      mfeat[c][i] = o;
    end
    mvalid[c] = 1'b1;
  endtask

  task automatic start_event(input int x, input int y);
    @(posedge clk); #1;
    new_event_x = x_idx_t'(x);
    new_event_y = y_idx_t'(y);
    last_layer_out_pack = pack_fv();
    module_start = 1'b1;
    @(posedge clk); #1;
    module_start = 1'b0;
  endtask

  task automatic run_event(input int x, input int y, input bit poke);
    int cyc, d0;
    d0 = done_cnt;
    start_event(x, y);
    cyc = 1;
    while (module_done !== 1'b1 && cyc < 20) begin
      module_start = (poke && cyc == 2);
      @(posedge clk); #1;
      cyc++;
    end
    module_start = 1'b0;
    check("done_cycle", PW'(cyc), PW'(6));
    model_event(x, y);
    check("busy_in_done", PW'(module_busy), PW'(1));
    check("grid_idx", PW'(grid_idx), PW'(exp_idx));
    check("cell_first", PW'(cell_first), PW'(exp_first));
    check("x_out", max_pool_x_out_pack, exp_out);
    check("dx_out", max_pool_dx_out_pack, exp_dx);
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_done", PW'({module_busy, module_done}), PW'(0));
    check("x_out_hold", max_pool_x_out_pack, exp_out);
    check("done_pulses", PW'(done_cnt - d0), PW'(1));
  endtask

  task automatic do_clean();
    @(posedge clk); #1;
    event_stream_clean = 1'b1;
    @(posedge clk); #1;
    event_stream_clean = 1'b0;
    model_clear();
  endtask

  typedef struct {
    int x; int y; int mode; bit clean_before; bit poke; int exp_idx; bit exp_first;
  } vec_t;

  vec_t tbl [5];
  int d0;

  initial begin
    tbl[0] = '{16, 16, 0, 1'b0, 1'b0, 9, 1'b1};
    tbl[1] = '{16, 16, 1, 1'b0, 1'b0, 9, 1'b0};
    tbl[2] = '{1, 1, 2, 1'b1, 1'b0, 0, 1'b1};
    tbl[3] = '{16, 16, 0, 1'b0, 1'b0, 9, 1'b1};
    tbl[4] = '{200, 255, 2, 1'b0, 1'b1, 63, 1'b1};
    model_clear();

    #1;
    check("rst_busy", PW'(module_busy), PW'(0));
    check("rst_done", PW'(module_done), PW'(0));
    check("rst_idx", PW'(grid_idx), PW'(0));
    check("rst_first", PW'(cell_first), PW'(0));
    check("rst_x", max_pool_x_out_pack, '0);
    check("rst_dx", max_pool_dx_out_pack, '0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    for (int v = 0; v < 5; v++) begin
      if (tbl[v].clean_before) do_clean();
      set_fv(tbl[v].mode);
      run_event(tbl[v].x, tbl[v].y, tbl[v].poke);
      check("tbl_idx", PW'(grid_idx), PW'(tbl[v].exp_idx));
      check("tbl_first", PW'(cell_first), PW'(tbl[v].exp_first));
    end

    // clean during PROC beat 2 aborts the event
    set_fv(3);
    d0 = done_cnt;
    start_event(16, 16);
    repeat (3) @(posedge clk);
    #1 event_stream_clean = 1'b1;
    @(posedge clk); #1;
    event_stream_clean = 1'b0;
    model_clear();
    check("abort_busy", PW'(module_busy), PW'(0));
    repeat (8) @(posedge clk);
    #1 check("abort_no_done", PW'(done_cnt - d0), PW'(0));
    set_fv(3);
    run_event(16, 16, 1'b0);
    check("abort_then_first", PW'(cell_first), PW'(1));

    // start and clean together: clean wins
    d0 = done_cnt;
    @(posedge clk); #1;
    module_start = 1'b1;
    event_stream_clean = 1'b1;
    @(posedge clk); #1;
    module_start = 1'b0;
    event_stream_clean = 1'b0;
    model_clear();
    check("both_busy", PW'(module_busy), PW'(0));
    repeat (8) @(posedge clk);
    #1 check("both_no_done", PW'(done_cnt - d0), PW'(0));
    set_fv(3);
    run_event(16, 16, 1'b0);

    // reset mid-event
    set_fv(3);
    d0 = done_cnt;
    start_event(40, 70);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_outs", PW'({module_busy, module_done, grid_idx, cell_first}), PW'(0));
    check("mid_rst_x", max_pool_x_out_pack, '0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("mid_rst_no_done", PW'(done_cnt - d0), PW'(0));

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 9) == 0) do_clean();
      set_fv(3);
      if (r % 2 == 0) run_event(int'($urandom_range(0, 47)), int'($urandom_range(0, 47)), 1'b0);
      else run_event(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), r % 5 == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/max_pool_grid.md
MAX_POOL_GRID -- requirements
Module: max_pool_grid

Interface
REQ-001 SHALL have parameter L_OUT_C, default 32: feature channels per event.
REQ-002 SHALL have parameter LANES, default 8: channels processed per cycle; L_OUT_C is an integer multiple of LANES.
REQ-003 SHALL have parameters GRID_W, GRID_H, default 8, 8: pooling grid size in cells.
REQ-004 SHALL have parameter CELL_SHIFT, default 4: cell edge = 2^CELL_SHIFT pixels.
REQ-005 SHALL use F_WIDTH, x_idx_t, y_idx_t and grid_idx_t from package aegnn; features are unsigned.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rstn  in  1  reset, asynchronous, active-low.
REQ-008 module_start  in  1  single-cycle pulse that starts an event.
REQ-009 event_stream_clean  in  1  single-cycle pulse that empties all cells.
REQ-010 new_event_x / new_event_y  in  x_idx_t / y_idx_t  event pixel coordinates.
REQ-011 last_layer_out_pack  in  L_OUT_C x F_WIDTH  upstream features.
REQ-012 module_busy  out  1  high while an event is being processed.
REQ-013 module_done  out  1  single-cycle completion pulse.
REQ-014 grid_idx  out  grid_idx_t  index of the cell just updated.
REQ-015 cell_first  out  1  cell was empty before this event.
REQ-016 max_pool_x_out_pack  out  L_OUT_C x F_WIDTH  updated cell maximum.
REQ-017 max_pool_dx_out_pack  out  L_OUT_C x F_WIDTH  new max minus old max.

Function
REQ-018 SHALL store per cell L_OUT_C features plus one valid bit; an invalid cell reads as all-zero.
REQ-019 SHALL compute cell coordinates cx = x>>CELL_SHIFT and cy = y>>CELL_SHIFT, each saturated to GRID_W-1 / GRID_H-1.
REQ-020 SHALL compute grid_idx = cy*GRID_W + cx.
REQ-021 SHALL implement FSM IDLE->CAPT on module_start, CAPT->PROC, PROC->DONE after L_OUT_C/LANES beats, DONE->IDLE.
REQ-022 In CAPT, SHALL latch the coordinates, the feature pack, the grid index and cell_first = !valid.
REQ-023 In each PROC beat k, SHALL process lanes k*LANES .. k*LANES+LANES-1: out = max(new, old), dx = out - old; out is written back to the cell.
REQ-024 dx SHALL be F_WIDTH wide and never wrap, since out >= old.
REQ-025 SHALL set the cell valid bit on the last PROC beat.
REQ-026 SHALL assert module_done exactly in DONE; module_start at cycle 0 gives done at cycle L_OUT_C/LANES + 2.
REQ-027 module_busy SHALL be high in CAPT, PROC and DONE.
REQ-028 module_start SHALL be ignored while busy.
REQ-029 Output packs, grid_idx and cell_first SHALL hold their values from done until the next CAPT.
REQ-030 event_stream_clean in IDLE SHALL clear all valid bits in one cycle; feature storage is untouched.
REQ-031 event_stream_clean while busy SHALL abort the event, clear all valid bits and return to IDLE with no done pulse; no partial cell write becomes valid.
REQ-032 With module_start and event_stream_clean in the same cycle, clean SHALL win and start SHALL be dropped.

Reset
REQ-033 rstn low SHALL force state IDLE and clear all valid bits.
REQ-034 rstn low SHALL drive all outputs to zero: module_busy=0, module_done=0, grid_idx=0, cell_first=0, both packs=0.
REQ-035 Reset asserted mid-event SHALL abort the event with no done pulse.

Configuration
REQ-036 With MAX_POOL_DX_EN defined, SHALL compute max_pool_dx_out_pack per REQ-023.
REQ-037 Without MAX_POOL_DX_EN, max_pool_dx_out_pack SHALL be constant zero and its subtractors absent; all other behaviour is unchanged.

Verification
REQ-038 Reset, then event (16,16) with feature[i]=i+1 -> grid_idx=9, cell_first=1, out[i]=i+1, dx[i]=i+1, done at cycle 6.
REQ-039 Repeat (16,16) with feature[i]=i+2 for i<31 and feature[31]=1 -> cell_first=0, out[i]=i+2 and dx[i]=1 for i<31, out[31]=32 and dx[31]=0.
REQ-040 Clean pulse, then event (1,1) with feature[i]=i -> grid_idx=0, cell_first=1, dx[i]=i; a new event at (16,16) then gives cell_first=1.
REQ-041 Event (200,255) -> grid_idx=63 (saturated); a second start during busy -> exactly one done pulse.
REQ-042 Clean asserted at PROC beat 2 -> no done, busy drops next cycle, the next event to that cell gives cell_first=1.
REQ-043 Start and clean in the same cycle -> no busy, no done; build without MAX_POOL_DX_EN -> dx=0 in all scenarios above.
